// File: rtl/dm_sts_monitor.sv
// Status-stream monitor for the AXI DataMover status channel: decodes status
// beats, matches returned tags against a FIFO of issued tags, keeps counters.
module dm_sts_monitor #(
    parameter int STS_W = 8,
    parameter int TAG_W = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     s_axi_clk,
    input  logic                     s_axi_resetn,
    input  logic [STS_W-1:0]         s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic [STS_W/8-1:0]       s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tready,
    input  logic                     cmd_push,
    input  logic [TAG_W-1:0]         cmd_tag,
    input  logic                     ack,
    input  logic                     cnt_clr,
    output logic                     pass,
    output logic                     fail,
    output logic [4:0]               err_code,
    output logic [TAG_W-1:0]         tag,
    output logic                     eop,
    output logic [22:0]              bytes_rcvd,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     ovf,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;

    logic             r_pass, r_fail, r_eop, r_ovf;
    logic [4:0]       r_err;
    logic [TAG_W-1:0] r_tag;
    logic [22:0]      r_bytes;
    logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;

    logic             w_evt, w_empty, w_full, w_pop, w_push, w_drop;
    logic             w_okay, w_slverr, w_decerr, w_interr;
    logic             w_good, w_evt_fail, w_eop;
    logic [TAG_W-1:0] w_sts_tag, w_head;
    logic [22:0]      w_bytes;
    logic [4:0]       w_err_new;
    logic             w_unused;

    assign w_unused  = ^{s_axis_tkeep, s_axis_tdata};

    assign w_okay    = s_axis_tdata[7];
    assign w_slverr  = s_axis_tdata[6];
    assign w_decerr  = s_axis_tdata[5];
    assign w_interr  = s_axis_tdata[4];
    assign w_sts_tag = s_axis_tdata[TAG_W-1:0];

    generate
        if (STS_W == 32) begin : g_wide
            assign w_eop   = s_axis_tdata[31];
            assign w_bytes = s_axis_tdata[30:8];
        end else begin : g_narrow
            assign w_eop   = 1'b0;
            assign w_bytes = '0;
        end
    endgenerate

    assign w_evt   = s_axis_tvalid & s_axis_tlast;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = w_evt & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign w_push  = cmd_push & (~w_full | w_pop);
    assign w_drop  = cmd_push & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    assign w_good     = w_okay & ~(w_slverr | w_decerr | w_interr) & ~w_empty &
                        (w_head == w_sts_tag);
    assign w_evt_fail = w_evt & ~w_good;
    assign w_err_new  = {w_empty, ~w_empty & (w_head != w_sts_tag),
                         w_interr, w_decerr, w_slverr};

    always_ff @(posedge s_axi_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_tag;
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_tag   <= '0;
            r_eop   <= 1'b0;
            r_bytes <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_pass <= w_evt & w_good;
            if (w_evt) begin
                r_tag   <= w_sts_tag;
                r_eop   <= w_eop;
                r_bytes <= w_bytes;
            end
            // A new failure beats ack; ack only discards the previously held bits.
            if (w_evt_fail) begin
                r_fail <= 1'b1;
                r_err  <= (ack ? 5'd0 : r_err) | w_err_new;
            end else if (ack) begin
                r_fail <= 1'b0;
                r_err  <= '0;
            end
            if (w_drop)   r_ovf <= 1'b1;
            else if (ack) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (cnt_clr) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            if (w_evt & w_good & (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + 1'b1;
            if (w_evt_fail & (r_fail_cnt != '1))     r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    assign m_axis_tready = 1'b1;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign err_code      = r_err;
    assign tag           = r_tag;
    assign eop           = r_eop;
    assign bytes_rcvd    = r_bytes;
    assign outstanding   = r_count;
    assign ovf           = r_ovf;
    assign pass_cnt      = r_pass_cnt;
    assign fail_cnt      = r_fail_cnt;

endmodule

// File: tb/tb_dm_sts_monitor.sv
// Bench for dm_sts_monitor: an 8-bit/2-bit-counter instance and a 32-bit/16-bit-counter
// instance share stimulus and are checked against a queue-based reference model.
module tb_dm_sts_monitor;
    logic        clk, rst_n;
    logic [31:0] tdata;
    logic        tvalid, tlast, cmd_push, ack, cnt_clr;
    logic [3:0]  cmd_tag;

    logic        a_rdy, a_pass, a_fail, a_eop, a_ovf;
    logic [4:0]  a_err;
    logic [3:0]  a_tag, a_out;
    logic [22:0] a_bytes;
    logic [1:0]  a_pc, a_fc;

    logic        b_rdy, b_pass, b_fail, b_eop, b_ovf;
    logic [4:0]  b_err;
    logic [3:0]  b_tag, b_out;
    logic [22:0] b_bytes;
    logic [15:0] b_pc, b_fc;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0]  q[$];
    logic        m_pass, m_fail, m_eop, m_ovf;
    logic [4:0]  m_err;
    logic [3:0]  m_tag;
    logic [22:0] m_bytes;
    int          m_pc_a, m_fc_a, m_pc_b, m_fc_b;

    dm_sts_monitor #(.STS_W(8), .TAG_W(4), .DEPTH(8), .CNT_W(2)) u_dut_a (
        .s_axi_clk(clk), .s_axi_resetn(rst_n), .s_axis_tdata(tdata[7:0]),
        .s_axis_tvalid(tvalid), .s_axis_tkeep(1'b1), .s_axis_tlast(tlast),
        .m_axis_tready(a_rdy), .cmd_push(cmd_push), .cmd_tag(cmd_tag), .ack(ack),
        .cnt_clr(cnt_clr), .pass(a_pass), .fail(a_fail), .err_code(a_err), .tag(a_tag),
        .eop(a_eop), .bytes_rcvd(a_bytes), .outstanding(a_out), .ovf(a_ovf),
        .pass_cnt(a_pc), .fail_cnt(a_fc)
    );

    dm_sts_monitor #(.STS_W(32), .TAG_W(4), .DEPTH(8), .CNT_W(16)) u_dut_b (
        .s_axi_clk(clk), .s_axi_resetn(rst_n), .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid), .s_axis_tkeep(4'hF), .s_axis_tlast(tlast),
        .m_axis_tready(b_rdy), .cmd_push(cmd_push), .cmd_tag(cmd_tag), .ack(ack),
        .cnt_clr(cnt_clr), .pass(b_pass), .fail(b_fail), .err_code(b_err), .tag(b_tag),
        .eop(b_eop), .bytes_rcvd(b_bytes), .outstanding(b_out), .ovf(b_ovf),
        .pass_cnt(b_pc), .fail_cnt(b_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pass = 0; m_fail = 0; m_eop = 0; m_ovf = 0;
        m_err = '0; m_tag = '0; m_bytes = '0;
        m_pc_a = 0; m_fc_a = 0; m_pc_b = 0; m_fc_b = 0;
    endtask

    task automatic check_all();
        chk("a_ready", 32'(a_rdy), 32'd1);
        chk("a_pass", 32'(a_pass), 32'(m_pass));
        chk("a_fail", 32'(a_fail), 32'(m_fail));
        chk("a_err", 32'(a_err), 32'(m_err));
        chk("a_tag", 32'(a_tag), 32'(m_tag));
        chk("a_eop", 32'(a_eop), 32'd0);
        chk("a_bytes", 32'(a_bytes), 32'd0);
        chk("a_out", 32'(a_out), 32'(q.size()));
        chk("a_ovf", 32'(a_ovf), 32'(m_ovf));
        chk("a_pass_cnt", 32'(a_pc), 32'(m_pc_a));
        chk("a_fail_cnt", 32'(a_fc), 32'(m_fc_a));
        chk("b_ready", 32'(b_rdy), 32'd1);
        chk("b_pass", 32'(b_pass), 32'(m_pass));
        chk("b_fail", 32'(b_fail), 32'(m_fail));
        chk("b_err", 32'(b_err), 32'(m_err));
        chk("b_tag", 32'(b_tag), 32'(m_tag));
        chk("b_eop", 32'(b_eop), 32'(m_eop));
        chk("b_bytes", 32'(b_bytes), 32'(m_bytes));
        chk("b_out", 32'(b_out), 32'(q.size()));
        chk("b_ovf", 32'(b_ovf), 32'(m_ovf));
        chk("b_pass_cnt", 32'(b_pc), 32'(m_pc_b));
        chk("b_fail_cnt", 32'(b_fc), 32'(m_fc_b));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), advance the
    // model by the rules of the monitor, then check every output after the edge.
    task automatic step(input bit p, input logic [3:0] t, input bit v, input bit l,
                        input logic [31:0] d, input bit a, input bit c);
        bit         evt, empty, full, good, bad;
        logic [3:0] head;
        cmd_push = p; cmd_tag = t; tvalid = v; tlast = l; tdata = d; ack = a; cnt_clr = c;

        evt   = v && l;
        empty = (q.size() == 0);
        full  = (q.size() == 8);
        head  = empty ? 4'd0 : q[0];
        good  = evt && d[7] && (d[6:4] == 3'd0) && !empty && (head == d[3:0]);
        bad   = evt && !good;

        m_pass = good;
        if (evt) begin
            m_tag = d[3:0]; m_eop = d[31]; m_bytes = d[30:8];
        end
        if (bad) begin
            m_fail = 1;
            m_err  = (a ? 5'd0 : m_err) |
                     {empty, !empty && (head != d[3:0]), d[4], d[5], d[6]};
        end else if (a) begin
            m_fail = 0; m_err = '0;
        end
        if (c) begin
            m_pc_a = 0; m_fc_a = 0; m_pc_b = 0; m_fc_b = 0;
        end else begin
            if (good) begin
                m_pc_a = (m_pc_a == 3) ? 3 : m_pc_a + 1;
                m_pc_b = (m_pc_b == 65535) ? 65535 : m_pc_b + 1;
            end
            if (bad) begin
                m_fc_a = (m_fc_a == 3) ? 3 : m_fc_a + 1;
                m_fc_b = (m_fc_b == 65535) ? 65535 : m_fc_b + 1;
            end
        end
        if (evt && !empty) void'(q.pop_front());
        if (p && full && !(evt && !empty)) m_ovf = 1;
        else begin
            if (p) q.push_back(t);
            if (a) m_ovf = 0;
        end

        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input logic [3:0] t);
        step(1, t, 0, 0, 32'd0, 0, 0);
    endtask

    task automatic sts(input logic [31:0] d);
        step(0, 4'd0, 1, 1, d, 0, 0);
    endtask

    task automatic idle();
        step(0, 4'd0, 0, 0, 32'd0, 0, 0);
    endtask

    initial begin
        rst_n = 0; tdata = '0; tvalid = 0; tlast = 0;
        cmd_push = 0; cmd_tag = '0; ack = 0; cnt_clr = 0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Basic good status
        push(4'd3);
        chk("out_after_push", 32'(a_out), 32'd1);
        sts(32'h83);
        chk("pass_pulse", 32'(a_pass), 32'd1);
        chk("tag3", 32'(b_tag), 32'd3);
        chk("pc1", 32'(a_pc), 32'd1);
        chk("out0", 32'(b_out), 32'd0);
        idle();
        chk("pass_one_cycle", 32'(a_pass), 32'd0);

        // SLVERR then ack
        push(4'd5);
        sts(32'hC5);
        chk("slverr_err", 32'(a_err), 32'h01);
        chk("slverr_fc", 32'(b_fc), 32'd1);
        step(0, 4'd0, 0, 0, 32'd0, 1, 0);
        chk("ack_fail", 32'(a_fail), 32'd0);
        chk("ack_err", 32'(b_err), 32'd0);

        // Tag mismatch, then orphan; beat without tlast has no effect
        push(4'd2);
        sts(32'h84);
        chk("mismatch", 32'(a_err), 32'h08);
        step(0, 4'd0, 1, 0, 32'hC7, 0, 0);
        sts(32'h80);
        chk("orphan", 32'(b_err), 32'h18);
        chk("fc_after_orphan", 32'(b_fc), 32'd3);

        // Fill, overflow, push+pop at full, drain
        for (int i = 0; i < 8; i++) push(4'(i));
        push(4'd9);
        chk("ovf_set", 32'(a_ovf), 32'd1);
        chk("full_out", 32'(b_out), 32'd8);
        step(1, 4'd10, 1, 1, 32'h80, 0, 0);
        chk("full_pushpop_out", 32'(a_out), 32'd8);
        for (int i = 1; i < 8; i++) begin
            sts(32'h80 | 32'(i));
            chk("drain_pass", 32'(b_pass), 32'd1);
        end
        sts(32'h8A);
        chk("drain_last", 32'(a_pass), 32'd1);
        chk("pc_sat", 32'(a_pc), 32'd3);
        chk("drain_empty", 32'(b_out), 32'd0);

        // 32-bit fields, with cnt_clr coinciding with a pass
        push(4'd1);
        step(0, 4'd0, 1, 1, 32'hC000_1281, 0, 1);
        chk("w_pass", 32'(b_pass), 32'd1);
        chk("w_eop", 32'(b_eop), 32'd1);
        chk("w_tag", 32'(b_tag), 32'd1);
        chk("clr_wins", 32'(a_pc), 32'd0);

        // ack with a simultaneous failure keeps only the new bits
        sts(32'h80);
        step(0, 4'd0, 1, 1, 32'hA0, 1, 0);
        chk("ack_vs_fail", 32'(a_err), 32'h12);
        chk("ack_vs_fail_f", 32'(b_fail), 32'd1);
        // push and pop on an empty FIFO: orphan, tag stored
        step(1, 4'd6, 1, 1, 32'h86, 0, 0);
        chk("empty_pushpop_out", 32'(a_out), 32'd1);
        chk("empty_pushpop_err", 32'(b_err), 32'h12 | 32'h10);
        step(0, 4'd0, 0, 0, 32'd0, 1, 0);
        chk("ovf_acked", 32'(a_ovf), 32'd0);

        // Asynchronous reset mid-queue
        push(4'd7);
        push(4'd8);
        cmd_push = 0; tvalid = 0; tlast = 0; ack = 0; cnt_clr = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_out", 32'(a_out), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_all();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit          p, v, l, a, c;
            logic [3:0]  t, st;
            logic [31:0] d;
            p  = ($urandom_range(0, 2) == 0);
            t  = 4'($urandom);
            v  = ($urandom_range(0, 2) != 0);
            l  = ($urandom_range(0, 4) != 0);
            st = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0] : 4'($urandom);
            d  = $urandom;
            d[7]   = ($urandom_range(0, 9) != 0);
            d[6:4] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
            d[3:0] = st;
            a  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 29) == 0);
            step(p, t, v, l, d, a, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
